dct_2d_row_ctrl: RTL and testbench

DCT_2D_ROW_CTRL -- requirements
Module: dct_2d_row_ctrl

---
 rtl/dct_pkg.sv | 16 +
 rtl/dct_tbuf.sv | 31 +++
 rtl/dct_2d_row_ctrl.sv | 120 ++++++++++++
 tb/tb_dct_2d_row_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and state encoding for the 2-D DCT row/transpose controller.
package dct_pkg;

   localparam int N        = 8;    // vector length, block rows and columns
   localparam int CORE_LAT = 6;    // core_en to matching core_valid, in cycles
   localparam int PIX_W    = 8;    // signed input pixel width
   localparam int COEF_W   = 10;   // signed 1-D DCT coefficient width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // waiting for the first row of a block
      ISSUE = 2'd1,   // rows being fed to the core
      FLUSH = 2'd2,   // all rows issued, waiting for the core to drain
      EMIT  = 2'd3    // transposed columns streaming out
   } state_t;

endpackage

// File: rtl/dct_tbuf.sv
// N x N transpose buffer: a whole row is written per cycle, a whole column
// is read combinationally. Contents are deliberately not reset.
module dct_tbuf #(
   parameter int N  = 8,
   parameter int W  = 10,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_row,
   input  logic [N*W-1:0]    wr_data,
   input  logic [IW-1:0]     rd_col,
   output logic [N*W-1:0]    rd_data
);

   // mem[row][k]: element k of the core result for block row 'row'
   logic [N-1:0][N-1:0][W-1:0] mem;

   // Row write from the core result bus
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_row] <= wr_data;
      end
   end

   // Column read: element r of the output column comes from stored row r
   for (genvar r = 0; r < N; r++) begin : g_col
      assign rd_data[r*W +: W] = mem[r][rd_col];
   end

endmodule

// File: rtl/dct_2d_row_ctrl.sv
// Row-side controller of a 2-D DCT: feeds N rows to an external 1-D core,
// captures the N results into a transpose buffer and streams them back out
// as N columns with a valid/ready handshake.
module dct_2d_row_ctrl #(
   parameter int N        = dct_pkg::N,
   parameter int CORE_LAT = dct_pkg::CORE_LAT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N*dct_pkg::PIX_W-1:0]   in_row,
   output logic                          core_en,
   output logic [N*dct_pkg::PIX_W-1:0]   core_x,
   input  logic [N*dct_pkg::COEF_W-1:0]  core_y,
   input  logic                          core_valid,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N*dct_pkg::COEF_W-1:0]  out_col,
   output logic                          out_last,
   output logic                          err
);

   import dct_pkg::*;

   // Counters must hold the value N itself (issue_cnt == N means "block full")
   localparam int CW = $clog2(N + 1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_N    = CW'(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // The core's latency is absorbed by FLUSH, so no logic depends on it;
   // only reject configurations the counters cannot handle.
   if (N < 2 || CORE_LAT < 1) begin : g_param_check
      $error("dct_2d_row_ctrl: N must be >= 2 and CORE_LAT >= 1");
   end

   state_t               state;
   logic [CW-1:0]        issue_cnt;
   logic [CW-1:0]        wr_cnt;
   logic [CW-1:0]        rd_cnt;
   logic                 cap_ok;
   logic                 cap_bad;
   logic [N*COEF_W-1:0]  col_data;

   // Rows go straight to the core; the core cannot be stalled, so acceptance
   // is only ever limited by the issue count.
   assign in_ready = ((state == IDLE) || (state == ISSUE)) && (issue_cnt < CNT_N);
   assign core_en  = in_valid & in_ready;
   assign core_x   = in_row;

   // A core result is only legal while a matching issued row is outstanding
   assign cap_ok  = core_valid && (wr_cnt < issue_cnt);
   assign cap_bad = core_valid && !(wr_cnt < issue_cnt);

   assign out_valid = (state == EMIT);
   assign out_last  = out_valid && (rd_cnt == CNT_LAST);
   assign out_col   = out_valid ? col_data : '0;

   // Block sequencing: issue N rows, capture N results, emit N columns
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         issue_cnt <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         err       <= 1'b0;
      end else begin
         // Unexpected core data is dropped; only the sticky flag records it
         if (cap_bad) begin
            err <= 1'b1;
         end
         if (cap_ok) begin
            wr_cnt <= wr_cnt + CNT_ONE;
         end
         case (state)
            IDLE, ISSUE: begin
               if (core_en) begin
                  issue_cnt <= issue_cnt + CNT_ONE;
                  state     <= (issue_cnt == CNT_LAST) ? FLUSH : ISSUE;
               end
            end
            FLUSH: begin
               // Nth capture: the buffer is complete from the next cycle on
               if (cap_ok && (wr_cnt == CNT_LAST)) begin
                  state <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (rd_cnt == CNT_LAST) begin
                     state     <= IDLE;
                     issue_cnt <= '0;
                     wr_cnt    <= '0;
                     rd_cnt    <= '0;
                  end else begin
                     rd_cnt <= rd_cnt + CNT_ONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   dct_tbuf #(
      .N  (N),
      .W  (COEF_W),
      .IW (IW)
   ) u_tbuf (
      .clk     (clk),
      .wr_en   (cap_ok),
      .wr_row  (wr_cnt[IW-1:0]),
      .wr_data (core_y),
      .rd_col  (rd_cnt[IW-1:0]),
      .rd_data (col_data)
   );

endmodule

// File: tb/tb_dct_2d_row_ctrl.sv
// Bench for dct_2d_row_ctrl: a behavioural 1-D core (real DCT or index echo)
// drives the DUT; a block-level transpose model predicts every column.
module tb_dct_2d_row_ctrl;

   localparam int N   = 8;
   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_row = '0;
   logic        core_en;
   logic [63:0] core_x;
   logic [79:0] core_y;
   logic        core_valid;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [79:0] out_col;
   logic        out_last;
   logic        err;

   always #5 clk = ~clk;

   dct_2d_row_ctrl #(.N(N), .CORE_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_row     (in_row),
      .core_en    (core_en),
      .core_x     (core_x),
      .core_y     (core_y),
      .core_valid (core_valid),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_col    (out_col),
      .out_last   (out_last),
      .err        (err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chkw(input string nm, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Core behaviour: mode 0 = scaled orthonormal 8-point DCT-II, rounded;
   // mode 1 = stub returning element k = r*8+k for row r of the block.
   int   core_mode = 0;
   logic inj = 1'b0;

   function automatic logic [79:0] core_fn(input logic [63:0] x, input int mode, input int r);
      logic [79:0] y;
      real         s, ck, v;
      int          yi;
      y = '0;
      for (int k = 0; k < N; k++) begin
         if (mode == 1) begin
            yi = r * 8 + k;
         end else begin
            s = 0.0;
            for (int n = 0; n < N; n++) begin
               s = s + real'($signed(x[n*8 +: 8])) * $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0);
            end
            ck = (k == 0) ? $sqrt(0.5) : 1.0;
            v  = 0.5 * ck * s;
            yi = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : $rtoi($ceil(v - 0.5));
         end
         y[k*10 +: 10] = yi[9:0];
      end
      return y;
   endfunction

   logic        pv [LAT];
   logic [79:0] pd [LAT];
   int          stub_r = 0;

   assign core_valid = pv[LAT-1] | inj;
   assign core_y     = pd[LAT-1];

   // Fixed-latency core pipeline, reset together with the controller
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
         stub_r <= 0;
      end else begin
         pv[0] <= core_en;
         pd[0] <= core_fn(core_x, core_mode, stub_r);
         for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         if (core_en) stub_r <= (stub_r + 1) % 8;
      end
   end

   // Block model: the expected output is simply the transpose of the
   // per-row core results, column c carrying element c of every row.
   typedef struct {
      logic [79:0] col;
      logic        last;
   } exp_t;

   exp_t        q [$];
   logic [9:0]  got [8][8];
   int          rx = 0;
   int          last_idx = -1;
   bit          mon_en = 1'b0;

   task automatic push_block(input logic [63:0] rows [8], input int mode);
      logic [79:0] yr [8];
      exp_t        e;
      for (int r = 0; r < N; r++) yr[r] = core_fn(rows[r], mode, r);
      for (int c = 0; c < N; c++) begin
         e.col = '0;
         for (int r = 0; r < N; r++) e.col[r*10 +: 10] = yr[r][c*10 +: 10];
         e.last = (c == N - 1);
         q.push_back(e);
      end
   endtask

   // Every-cycle output check against the model queue
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            chk1("in_ready_in_emit", in_ready, 1'b0);
            if (q.size() == 0) begin
               chk1("unexpected_column", out_valid, 1'b0);
            end else begin
               chkw("out_col", out_col, q[0].col);
               chk1("out_last", out_last, q[0].last);
               if (out_ready) begin
                  for (int r = 0; r < N; r++) got[rx % 8][r] = out_col[r*10 +: 10];
                  if (out_last) last_idx = rx % 8;
                  rx++;
                  void'(q.pop_front());
               end
            end
         end else begin
            chkw("out_col_gated", out_col, 80'd0);
            chk1("out_last_idle", out_last, 1'b0);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      inj = 1'b0;
      tick();
      rst = 1'b0;
      q.delete();
      rx = 0;
      last_idx = -1;
   endtask

   // Offer rows; gap>0 idles in_valid between rows; hold keeps in_valid high
   task automatic send_rows(input logic [63:0] rows [8], input int gap, input bit hold);
      bit acc;
      int n;
      for (int i = 0; i < N; i++) begin
         in_row = rows[i];
         in_valid = 1'b1;
         acc = 1'b0;
         n = 0;
         while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
         end
         if (!acc) chki("accept_timeout", n, 0);
         if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
         end
      end
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_done;
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((q.size() != 0 || out_valid) && n < 2000);
      chki("block_timeout", q.size(), 0);
   endtask

   // Literal pins for the all-16 block: DC = 45, everything else 0
   task automatic check_flat16(input string tag);
      for (int r = 0; r < N; r++) chkw({tag, "_col0"}, 80'(got[0][r]), 80'd45);
      for (int c = 1; c < N; c++)
         for (int r = 0; r < N; r++) chkw({tag, "_acol"}, 80'(got[c][r]), 80'd0);
      chki({tag, "_ncols"}, rx, 8);
      chki({tag, "_last_at"}, last_idx, 7);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] flat [8];
      logic [63:0] rows [8];
      logic [79:0] first;
      int          n, hs;

      for (int i = 0; i < N; i++) flat[i] = 64'h1010_1010_1010_1010;

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_err", err, 1'b0);
      chk1("rst_core_en", core_en, 1'b0);
      chk1("rst_out_last", out_last, 1'b0);
      tick();

      // Real core, back-to-back flat rows, downstream always ready
      core_mode = 0;
      out_ready = 1'b1;
      push_block(flat, 0);
      send_rows(flat, 0, 0);
      wait_done();
      check_flat16("t1");

      // Stub echo core: column c element r must be r*8+c
      do_reset();
      core_mode = 1;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) rows[i] = {$urandom, $urandom};
      push_block(rows, 1);
      send_rows(rows, 0, 0);
      wait_done();
      for (int c = 0; c < N; c++)
         for (int r = 0; r < N; r++) chkw("t2_echo", 80'(got[c][r]), 80'(r * 8 + c));
      chki("t2_ncols", rx, 8);

      // Sparse input, downstream stalled 10 cycles at the start of EMIT
      do_reset();
      core_mode = 0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) rows[i] = {$urandom, $urandom};
      push_block(rows, 0);
      send_rows(rows, 1, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 500);
      chk1("t3_emit_reached", out_valid, 1'b1);
      first = out_col;
      repeat (10) begin
         @(negedge clk);
         chkw("t3_hold", out_col, first);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_done();
      chki("t3_ncols", rx, 8);

      // Reset after the fourth column handshake, then a clean block
      do_reset();
      core_mode = 0;
      out_ready = 1'b1;
      push_block(flat, 0);
      send_rows(flat, 0, 0);
      hs = 0;
      n = 0;
      while (hs < 4 && n < 500) begin
         @(negedge clk);
         if (out_valid && out_ready) hs++;
         n++;
      end
      chki("t4_handshakes", hs, 4);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      rx = 0;
      last_idx = -1;
      @(negedge clk);
      chk1("t4_out_valid", out_valid, 1'b0);
      chk1("t4_in_ready", in_ready, 1'b1);
      chk1("t4_err", err, 1'b0);
      tick();
      out_ready = 1'b1;
      push_block(flat, 0);
      send_rows(flat, 0, 0);
      wait_done();
      check_flat16("t4");

      // Spurious core_valid in IDLE: sticky err, block still correct
      inj = 1'b1;
      tick();
      inj = 1'b0;
      @(negedge clk);
      chk1("t5_err_set", err, 1'b1);
      chk1("t5_idle_ready", in_ready, 1'b1);
      repeat (3) tick();
      chk1("t5_err_sticky", err, 1'b1);
      rx = 0;
      last_idx = -1;
      out_ready = 1'b1;
      push_block(flat, 0);
      send_rows(flat, 0, 0);
      wait_done();
      check_flat16("t5");
      chk1("t5_err_after_block", err, 1'b1);
      do_reset();
      @(negedge clk);
      chk1("t5_err_cleared", err, 1'b0);
      tick();

      // Ninth row held valid through FLUSH/EMIT: no acceptance until IDLE
      out_ready = 1'b1;
      push_block(flat, 0);
      send_rows(flat, 0, 1);
      in_row = 64'h0102_0304_0506_0708;
      n = 0;
      while (n < 500) begin
         @(negedge clk);
         if (in_ready) break;
         chk1("t6_core_en_blocked", core_en, 1'b0);
         n++;
      end
      chki("t6_cols_before_ready", rx, 8);
      chk1("t6_core_en_resume", core_en, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      do_reset();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
